seven_seg_scan: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 41 ++++
 rtl/seg_decoder.sv | 11 +
 rtl/seven_seg_scan.sv | 73 +++++++
 tb/tb_seven_seg_scan.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns, score word type and digit decode for the seven-segment scanner
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic       s;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } score_t;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: BCD nibble to active-low gfedcba pattern, non-digits shown as a dash
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = decode(nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode scanner with per-frame snapshot; LEADING_ZERO_BLANK_EN blanks leading zeros
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;
    score_t        snap;
    logic          slot_end;
    logic [3:0]    nibble;
    logic [6:0]    pattern;
    logic [3:0]    lead_zero;
    logic          blank_digit;

    assign slot_end = slot_cnt == CW'(REFRESH_DIV - 1);
    assign nibble   = digit_idx == 2'd3 ? snap.d3 :
                      digit_idx == 2'd2 ? snap.d2 :
                      digit_idx == 2'd1 ? snap.d1 : snap.d0;

`ifdef LEADING_ZERO_BLANK_EN
    assign lead_zero[3] = snap.d3 == 4'd0;
    assign lead_zero[2] = lead_zero[3] && snap.d2 == 4'd0;
    assign lead_zero[1] = lead_zero[2] && snap.d1 == 4'd0;
    assign lead_zero[0] = 1'b0;
`else
    assign lead_zero = 4'b0000;
`endif
    assign blank_digit = lead_zero[digit_idx];

    seg_decoder u_dec (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // Slot timer, digit rotation, and snapshot of the score at the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
            snap      <= '0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) digit_idx <= digit_idx + 2'd1;
            if (slot_end && digit_idx == 2'd3) snap <= bcd;
        end
    end

    // Registered pin drivers: dark during the anti-ghosting gap, else one digit lit
    always_ff @(posedge clk) begin
        if (reset || slot_cnt < CW'(BLANK_CYC)) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= blank_digit ? SEG_BLANK : pattern;
            dp  <= ~(snap.s && digit_idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: randomized and directed checks of the scanner against a tick-count reference model
module tb_seven_seg_scan;

    localparam int R = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] bcd = 17'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ticks = 0;
    logic [16:0] msnap = 17'h0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic        chk_on = 1'b0;

    seven_seg_scan #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bcd   (bcd),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected pins for the cycle whose pre-edge time since reset is t, given the frame's score
    function automatic logic [11:0] expect_out(input int t, input logic [16:0] s);
        int slot;
        int d;
        logic [15:0] upper;
        logic [6:0] g;
        slot = t % R;
        d = (t / R) % 4;
        if (slot < B) return {4'hF, 7'h7F, 1'b1};
        upper = s[15:0] >> (4 * d);
        g = seg_ref(int'(upper[3:0]));
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && upper == 16'd0) g = 7'h7F;
`endif
        return {~(4'b0001 << d), g, ~(s[16] && d == 3)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ticks <= 0;
            msnap <= 17'h0;
            {exp_an, exp_seg, exp_dp} <= {4'hF, 7'h7F, 1'b1};
        end else begin
            ticks <= ticks + 1;
            if (ticks % (4 * R) == 4 * R - 1) msnap <= bcd;
            {exp_an, exp_seg, exp_dp} <= expect_out(ticks, msnap);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
            check("dp", 32'(dp), 32'(exp_dp));
            if (an != 4'hF) check("an_onehot", $countones(~an), 1);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_digit(input int d, input int slot, input string tag);
        int k;
        for (k = 0; k < 4 * R; k++) begin
            if ((ticks / R) % 4 == d && ticks % R == slot) break;
            @(negedge clk);
        end
        if (k == 4 * R) check(tag, 0, 1);
    endtask

    initial begin
        @(posedge clk);
        chk_on = 1'b1;
        run(3);
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        reset = 1'b0;
        bcd = 17'h0_1234;
        run(8 * R + 2);
        bcd = 17'h1_0507;
        run(8 * R + 4);
        bcd = 17'h0_1111;
        wait_digit(0, 0, "wait_frame");
        wait_digit(1, 3, "wait_digit1");
        bcd = 17'h0_9999;
        run(8 * R);
        bcd = 17'h0_00AF;
        run(8 * R);
        bcd = 17'h0_0042;
        run(8 * R);
        bcd = 17'h0_0100;
        run(8 * R);
        for (int i = 0; i < 30; i++) begin
            bcd = 17'($urandom);
            run($urandom_range(1, 5 * R));
        end
        bcd = 17'h0_5678;
        run(8 * R);
        wait_digit(2, 5, "wait_mid");
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("midreset_an", 32'(an), 32'hF);
        check("midreset_seg", 32'(seg), 32'h7F);
        run(B + 1);
        check("resume_an", 32'(an), 32'hE);
        run(8 * R);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
